// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hard-wired zero register index and the default register-index width.
package hazard_pkg;

    localparam int HAZ_REG_W = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the hazard controller performance
// statistics; clears on rst and holds once it reaches all-ones.
module hazard_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // count one event per cycle, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {W{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline controller: load-use stall, taken-branch flush and
// frozen data-memory handshake with timeout. Optional counters: HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = HAZ_REG_W,
    parameter int MEM_TIMEOUT = 8
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W       = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             idex_memr,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zflag,
    input  logic             exmem_memr,
    input  logic             exmem_memw,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_src,
    output logic             mem_req,
    output logic             mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_lduse
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state_r;
    hz_state_e         state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic              mem_err_r;
    logic              set_err_s;

    logic memop_s;
    logic taken_s;
    logic lduse_s;
    logic freeze_s;
    logic flush_s;
    logic stall_s;
    logic mem_req_s;

    assign memop_s = exmem_memr | exmem_memw;
    assign taken_s = exmem_branch & exmem_zflag;
    assign lduse_s = idex_memr & (idex_rt != REG_W'(REG_ZERO)) &
                     ((idex_rt == id_rs) | (idex_rt == id_rt));

    // hazard arbitration: freeze beats branch flush beats load-use
    always_comb begin
        freeze_s    = 1'b0;
        flush_s     = 1'b0;
        stall_s     = 1'b0;
        mem_req_s   = 1'b0;
        set_err_s   = 1'b0;
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        if (rst) begin
            state_nxt_s = ST_RUN;
            wait_nxt_s  = {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    mem_req_s = memop_s;
                    // an acknowledged access still masks a branch in the same cycle
                    if (memop_s && !mem_ack) begin
                        freeze_s    = 1'b1;
                        state_nxt_s = ST_MEM_WAIT;
                        wait_nxt_s  = WAIT_W'(1);
                    end else if (taken_s && !memop_s) begin
                        flush_s = 1'b1;
                    end else if (lduse_s) begin
                        stall_s = 1'b1;
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                ST_MEM_WAIT: begin
                    mem_req_s = 1'b1;
                    if (mem_ack) begin
                        state_nxt_s = ST_RUN;
                        wait_nxt_s  = {WAIT_W{1'b0}};
                    end else if (wait_cnt_r == WAIT_MAX) begin
                        state_nxt_s = ST_RUN;
                        wait_nxt_s  = {WAIT_W{1'b0}};
                        set_err_s   = 1'b1;
                    end else begin
                        freeze_s   = 1'b1;
                        wait_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    wait_nxt_s  = {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // FSM, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_nxt_s;
            mem_err_r  <= mem_err_r | set_err_s;
        end
    end

    assign pc_write    = ~(freeze_s | stall_s);
    assign ifid_write  = ~(freeze_s | stall_s);
    assign idex_write  = ~freeze_s;
    assign exmem_write = ~freeze_s;
    assign idex_bubble = stall_s;
    assign ifid_flush  = flush_s;
    assign idex_flush  = flush_s;
    assign exmem_flush = flush_s;
    assign pc_src      = flush_s;
    assign mem_req     = mem_req_s;
    assign mem_err     = mem_err_r;

`ifdef HAZ_PERF_CNT_EN
    logic stall_evt_s;

    assign stall_evt_s = freeze_s | stall_s;

    hazard_perf_cnt #(.W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_evt_s),
        .count (perf_stall)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_s),
        .count (perf_flush)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_cnt_lduse (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_s),
        .count (perf_lduse)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed cases with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int TO    = 4;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [REG_W-1:0] id_rs, id_rt, idex_rt;
    logic idex_memr, exmem_branch, exmem_zflag, exmem_memr, exmem_memw, mem_ack;
    logic pc_write, ifid_write, idex_write, exmem_write, idex_bubble;
    logic ifid_flush, idex_flush, exmem_flush, pc_src, mem_req, mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall, perf_flush, perf_lduse;
`endif

    pipeline_hazard_ctrl #(
        .REG_W       (REG_W),
        .MEM_TIMEOUT (TO)
`ifdef HAZ_PERF_CNT_EN
        ,
        .CNT_W       (CNT_W)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .idex_memr    (idex_memr),
        .idex_rt      (idex_rt),
        .exmem_branch (exmem_branch),
        .exmem_zflag  (exmem_zflag),
        .exmem_memr   (exmem_memr),
        .exmem_memw   (exmem_memw),
        .mem_ack      (mem_ack),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .exmem_write  (exmem_write),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .pc_src       (pc_src),
        .mem_req      (mem_req),
        .mem_err      (mem_err)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
        .perf_lduse   (perf_lduse)
`endif
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write, idex_write, exmem_write, bubble, 3 flushes, pc_src, mem_req, mem_err}
    logic [10:0] ctl_vec;
    assign ctl_vec = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
                      ifid_flush, idex_flush, exmem_flush, pc_src, mem_req, mem_err};

    int n_cmp = 0;
    int n_bad = 0;

    // model state: cycles already frozen for the pending access (0 = none)
    int m_frozen = 0;
    bit m_err    = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;
    int m_lduse  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input bit ev);
        return (ev && v < CMAX) ? v + 1 : v;
    endfunction

    // wait for the mid-cycle point, compare against the model, then advance the model
    task automatic check_cycle();
        bit fr, fl, st, req, memop, taken, lduse;
        int nf;
        bit ne;
        logic [10:0] exp;
        @(negedge clk);
        fr = 1'b0; fl = 1'b0; st = 1'b0; req = 1'b0;
        nf = m_frozen; ne = m_err;
        memop = exmem_memr | exmem_memw;
        taken = exmem_branch & exmem_zflag;
        lduse = idex_memr && (idex_rt != 0) && (idex_rt == id_rs || idex_rt == id_rt);
        if (rst) begin
            nf = 0; ne = 1'b0;
        end else if (m_frozen > 0) begin
            req = 1'b1;
            nf = 0;
            if (!mem_ack) begin
                if (m_frozen == TO) ne = 1'b1;
                else begin fr = 1'b1; nf = m_frozen + 1; end
            end
        end else begin
            req = memop;
            if (memop && !mem_ack) begin fr = 1'b1; nf = 1; end
            else if (taken && !memop) fl = 1'b1;
            else if (lduse) st = 1'b1;
        end
        exp = {!(fr || st), !(fr || st), !fr, !fr, st, fl, fl, fl, fl, req, m_err};
        chk("ctl", 32'(ctl_vec), 32'(exp));
`ifdef HAZ_PERF_CNT_EN
        chk("perf_stall", 32'(perf_stall), m_stall);
        chk("perf_flush", 32'(perf_flush), m_flush);
        chk("perf_lduse", 32'(perf_lduse), m_lduse);
`endif
        if (rst) begin
            m_stall = 0; m_flush = 0; m_lduse = 0;
        end else begin
            m_stall = sat_inc(m_stall, fr || st);
            m_flush = sat_inc(m_flush, fl);
            m_lduse = sat_inc(m_lduse, st);
        end
        m_frozen = nf;
        m_err    = ne;
    endtask

    task automatic idle();
        rst = 1'b0; id_rs = '0; id_rt = '0; idex_memr = 1'b0; idex_rt = '0;
        exmem_branch = 1'b0; exmem_zflag = 1'b0; exmem_memr = 1'b0;
        exmem_memw = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        check_cycle();
        chk("rst_defaults", 32'(ctl_vec[10:1]), 32'h3C0);
        next_cycle();
        idle();
    endtask

    int req_cnt, frz_cnt;

    initial begin
        idle();
        rst = 1'b1;
        #1;
        do_reset();

        // load-use stall then defaults
        idex_memr = 1'b1; idex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd7;
        check_cycle();
        chk("lduse_stall", 32'({pc_write, ifid_write, idex_bubble}), 32'b001);
        next_cycle();
        idle();
        check_cycle();
        chk("lduse_release", 32'(ctl_vec), 32'h780);
        next_cycle();

        // load to r0 never stalls
        idex_memr = 1'b1; idex_rt = 5'd0; id_rt = 5'd0;
        check_cycle();
        chk("lduse_r0", 32'(ctl_vec), 32'h780);
        next_cycle();

        // branch beats load-use
        idex_memr = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
        exmem_branch = 1'b1; exmem_zflag = 1'b1;
        check_cycle();
        chk("branch_flush",
            32'({pc_src, ifid_flush, idex_flush, exmem_flush, pc_write, idex_bubble}),
            32'b111110);
        next_cycle();
        idle();

        // load with ack three cycles late
        req_cnt = 0; frz_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            exmem_memr = 1'b1;
            mem_ack = (i == 3);
            check_cycle();
            if (mem_req) req_cnt++;
            if (!pc_write) frz_cnt++;
            if (i == 3)
                chk("ack_enables", 32'({pc_write, ifid_write, idex_write, exmem_write}), 32'hF);
            next_cycle();
        end
        idle();
        chk("ack_req_cycles", req_cnt, 4);
        chk("ack_freeze_cycles", frz_cnt, 3);
        check_cycle();
        chk("ack_no_err", 32'(mem_err), 32'd0);
        next_cycle();

        // store without ack times out
        frz_cnt = 0;
        for (int i = 0; i < TO + 1; i++) begin
            exmem_memw = 1'b1;
            check_cycle();
            if (!exmem_write) frz_cnt++;
            if (i == TO)
                chk("timeout_release", 32'({pc_write, exmem_write, mem_req}), 32'b111);
            next_cycle();
        end
        idle();
        chk("timeout_freeze_cycles", frz_cnt, TO);
        for (int i = 0; i < 20; i++) begin
            check_cycle();
            next_cycle();
        end
        check_cycle();
        chk("err_sticky", 32'(mem_err), 32'd1);
        next_cycle();

        // reset in the second wait cycle abandons the access
        for (int i = 0; i < 2; i++) begin
            exmem_memr = 1'b1;
            check_cycle();
            next_cycle();
        end
        rst = 1'b1;
        check_cycle();
        chk("rst_no_req", 32'(mem_req), 32'd0);
        next_cycle();
        idle();
        check_cycle();
        chk("rst_clears_err", 32'({mem_err, mem_req, pc_write}), 32'b001);
`ifdef HAZ_PERF_CNT_EN
        chk("rst_perf_zero", 32'(perf_stall) | 32'(perf_flush) | 32'(perf_lduse), 32'd0);
`endif
        next_cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            id_rs        = REG_W'($urandom_range(0, 3));
            id_rt        = REG_W'($urandom_range(0, 3));
            idex_rt      = REG_W'($urandom_range(0, 3));
            idex_memr    = ($urandom_range(0, 2) == 0);
            exmem_branch = ($urandom_range(0, 3) == 0);
            exmem_zflag  = ($urandom_range(0, 1) == 0);
            exmem_memr   = ($urandom_range(0, 9) == 0);
            exmem_memw   = ($urandom_range(0, 9) == 0);
            mem_ack      = ($urandom_range(0, 3) == 0);
            check_cycle();
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central pipeline controller for the 5-stage datapath. It generates the write-enable, bubble and flush controls for the IF/ID, ID/EX and EX/MEM buffers and the PC. It detects load-use hazards and taken branches resolved at the EX/MEM outputs. It also sequences data-memory accesses through a request/acknowledge handshake with a timeout.

## Interface
- `REG_W`, 5: register-index width
- `MEM_TIMEOUT`, 8: maximum frozen cycles per memory access, ≥1
- `CNT_W`, 16: performance-counter width (only with macro)

Ports, listed as name, direction, width, meaning:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous reset, active-high
- `id_rs`, `id_rt` in REG_W: source registers of the instruction in ID
- `idex_memr` in 1: ID/EX instruction is a load
- `idex_rt` in REG_W: load destination in ID/EX
- `exmem_branch`, `exmem_zflag` in 1: branch flag and zero flag at the EX/MEM outputs
- `exmem_memr`, `exmem_memw` in 1: memory read or write in the MEM stage
- `mem_ack` in 1: data memory completes the access this cycle
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write` out 1: register/buffer update enables
- `idex_bubble` out 1: load zeroed control into ID/EX
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: clear the buffer on the next edge
- `pc_src` out 1: select branch target
- `mem_req` out 1: data-memory request
- `mem_err` out 1: sticky timeout flag
- `perf_stall`, `perf_flush`, `perf_lduse` out CNT_W: counters (macro only)

## Operation
- FSM states are RUN and MEM_WAIT. The wait counter `wait_cnt` has width $clog2(MEM_TIMEOUT+1).
- Let `memop = exmem_memr | exmem_memw`.
- Let `taken = exmem_branch & exmem_zflag`.
- Let `lduse = idex_memr & (idex_rt != 0) & ((idex_rt == id_rs) | (idex_rt == id_rt))`.
- Priority order: rst, then memory freeze, then branch flush, then load-use.
- **Default outputs:** all write enables = 1; bubble, flushes, pc_src and mem_req = 0.
- **RUN with memop:**
  - mem_req = 1.
  - If `!mem_ack`: freeze (all four write enables = 0), next state MEM_WAIT, `wait_cnt` ← 1.
  - If `mem_ack`: no freeze.
- **MEM_WAIT:**
  - mem_req = 1.
  - If `mem_ack`: release (defaults), next state RUN.
  - Else if `wait_cnt == MEM_TIMEOUT`: forced release, `mem_err` ← 1, next state RUN.
  - Else: freeze, `wait_cnt` increments.
- **Branch taken** (RUN, no freeze): pc_src = 1; ifid_flush, idex_flush and exmem_flush = 1; write enables stay 1; load-use is ignored.
- **Load-use** (RUN, no freeze, not taken): pc_write = 0, ifid_write = 0, idex_bubble = 1 for that cycle.
- Simultaneous events:
  - Freeze masks both branch and load-use; their outputs stay 0 until release.
  - memop together with taken is illegal; memop wins.
- `mem_err` is cleared only by `rst`.

## Timing
- All control outputs are combinational from inputs and state, valid in the same cycle. State, `wait_cnt`, `mem_err` and the counters are registered.
- Load-use stall lasts exactly 1 cycle per hazard instance.
- Branch flush lasts 1 cycle. The target PC loads on the same edge.
- Memory handshake:
  - Ack delayed by N cycles (N < MEM_TIMEOUT): freeze for N cycles; mem_req high for N+1 cycles; advance on the ack cycle.
  - No ack: freeze for exactly MEM_TIMEOUT cycles; release on the next cycle.
- While `rst` = 1: outputs take their defaults, mem_req = 0, and mem_err = 0 on the next edge.
- After the reset edge: state = RUN, `wait_cnt` = 0, counters = 0.
- Reset during MEM_WAIT abandons the access; no mem_err is set.

## Configuration
- Macro: `HAZ_PERF_CNT_EN`.
- **Defined:** three saturating CNT_W counters.
  - `perf_stall`: +1 per freeze cycle or load-use cycle.
  - `perf_flush`: +1 per branch-flush cycle.
  - `perf_lduse`: +1 per load-use cycle.
  - All counters are cleared by rst and hold at all-ones.
- **Undefined:** the counter ports and logic are absent; control behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - state encoding (RUN, MEM_WAIT)
  - `REG_ZERO` constant
  - default REG_W
- Sub-module `hazard_perf_cnt`: one parameterized saturating counter, instantiated three times under the macro.
- The FSM and hazard decode stay in the top module.

## Test plan
- `idex_memr` = 1, `idex_rt` = 5, `id_rs` = 5 → same cycle: pc_write = 0, ifid_write = 0, idex_bubble = 1. Next cycle with `idex_memr` = 0 → defaults.
- `idex_memr` = 1, `idex_rt` = 0, `id_rt` = 0 → no stall; all outputs at defaults.
- `exmem_branch` = 1, `exmem_zflag` = 1 together with the load-use condition from case 1 → pc_src = 1, three flushes = 1, pc_write = 1, idex_bubble = 0.
- `exmem_memr` = 1, `mem_ack` raised 3 cycles later, MEM_TIMEOUT = 8 → mem_req high for 4 cycles, freeze for 3 cycles, enables = 1 in the ack cycle, mem_err = 0.
- MEM_TIMEOUT = 4, `exmem_memw` = 1, no ack → freeze for 4 cycles, release in the 5th cycle, mem_err = 1 and still 1 after 20 more cycles until rst.
- rst asserted in the 2nd MEM_WAIT cycle → mem_req = 0 during reset; afterwards state RUN, mem_err = 0, perf counters = 0 (macro build).
